copro_arith_unit: RTL
=====================

# copro_arith_unit

Parametrised, multicycle successor to the LM32 coprocessor datapath. It executes the user-defined-instruction opcodes add, sub, mul-low and mul-high (new) on WIDTH-bit operands, and uses a valid/complete handshake so the CPU stalls until the result is ready. Add and sub finish in one registered cycle. Multiplies run on an iterative shift-add engine that takes WIDTH cycles, replacing the single-cycle combinational multiplier. The block sits between the LM32 user-instruction port and the register-file writeback.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4.
- OPCODE_W, 11, opcode width (LM32 user-instruction field).

Ports (one clock, `clk_i`; reset `rst_i` is synchronous and active-high):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  request strobe; sampled only when busy_o=0.
- opcode_i  in  OPCODE_W  operation select.
- op0_i  in  WIDTH  operand 0 (multiplicand / minuend).
- op1_i  in  WIDTH  operand 1 (multiplier / subtrahend).
- result_o  out  WIDTH  registered result; holds until the next completion.
- complete_o  out  1  one-cycle pulse; result_o is valid in this cycle.
- busy_o  out  1  high while a multiply is in progress.

## Operation
- Opcodes:
  - 0: op0+op1, mod 2^WIDTH.
  - 1: op0−op1, mod 2^WIDTH.
  - 2: low WIDTH bits of the unsigned product op0·op1.
  - 3: high WIDTH bits of that product.
  - Any other value: result 0, completes like add.
- Acceptance: a request is accepted on a rising edge where valid_i=1 and state=IDLE. Operands and opcode are captured at acceptance; later input changes have no effect.
- FSM states:
  - IDLE: on accept with opcode 2/3 → MUL. On accept with any other opcode, stay in IDLE; load result_o and set complete_o=1 for the next cycle.
  - MUL: iterative engine. Registers: 2·WIDTH-bit accumulator/product P, WIDTH-bit multiplicand M, counter cnt of width $clog2(WIDTH+1).
    - At accept: P={WIDTH'0, op1}, M=op0, cnt=WIDTH, selector latched.
    - Each cycle: if P[0]=1, add M to P[2W−1:W] with carry into a (WIDTH+1)-bit upper sum. Then shift {carry,upper,lower} right by 1 and decrement cnt.
    - When cnt reaches 0 → IDLE. result_o = P[W−1:0] (op 2) or P[2W−1:W] (op 3); complete_o=1 for one cycle.
- busy_o = (state==MUL). valid_i asserted while busy_o=1 is ignored; no queueing, no error flag.
- complete_o is high for exactly one cycle per accepted request. It deasserts automatically even if valid_i stays high.
- Back-to-back: a new request may be accepted in the same cycle that complete_o=1, since the state is IDLE then.
- Reset:
  - result_o=0, complete_o=0, busy_o=0, state=IDLE, P/M/cnt=0.
  - Reset mid-multiply aborts the operation; no complete pulse is ever produced for it.
  - valid_i during reset is ignored.

## Timing
- Add/sub/other: accepted at edge N → complete_o=1 and result_o valid in cycle N+1. Latency 1, throughput 1 per cycle.
- Mul (op 2/3): accepted at edge N.
  - busy_o=1 during cycles N+1 … N+WIDTH.
  - complete_o=1 in cycle N+WIDTH+1, with busy_o=0 in that cycle.
  - Latency WIDTH+1 cycles; the next accept is possible at edge N+WIDTH+1.
- result_o changes only at a completion edge or at reset; it is otherwise stable.
- Critical path: one (WIDTH+1)-bit adder plus a mux. No combinational path from inputs to outputs.

## Test plan
- Reset/idle: assert rst_i for 2 cycles with valid_i=1, then release → result_o=0, complete_o=0, busy_o=0 throughout; no spurious pulse.
- Add/sub wrap (WIDTH=32):
  - op 0, 0xFFFFFFFF + 0x00000002 → 0x00000001, complete_o exactly 1 cycle after accept.
  - op 1, 0x00000000 − 0x00000001 → 0xFFFFFFFF.
- Multiply (WIDTH=32):
  - op 2, 0x0001_0003 · 0x0000_0005 → 0x0005_000F, complete_o at accept+33, busy_o high for 32 cycles.
  - op 3, 0xFFFFFFFF · 0xFFFFFFFF → 0xFFFFFFFE; op 2 on the same operands → 0x00000001.
- Busy protection: start op 2 with 7·9, then pulse valid_i op 0 with 1+1 during busy → only a single complete pulse occurs, with result 63; the add is dropped.
- Back-to-back and abort:
  - Present op 0 requests continuously → complete_o high every cycle with the matching sums.
  - Start op 2, assert rst_i at accept+10 → no complete pulse, result_o=0.
  - A following op 2 with 3·4 returns 12 at accept+33.
- Parametrisation: rerun the multiply and wrap cases at WIDTH=8.
  - op 3, 0xFF·0xFF → 0xFE, with latency 9.
  - op 2 → 0x01.

Source files
------------

// File: rtl/copro_arith_unit_if.sv
// Request/response bundle between the LM32 user-instruction port and the
// arithmetic coprocessor: operands and opcode in, registered result and status out.
interface copro_arith_unit_if #(
  parameter int WIDTH    = 32,
  parameter int OPCODE_W = 11
);
  logic                valid_i;
  logic [OPCODE_W-1:0] opcode_i;
  logic [WIDTH-1:0]    op0_i;
  logic [WIDTH-1:0]    op1_i;
  logic [WIDTH-1:0]    result_o;
  logic                complete_o;
  logic                busy_o;

  modport master (
    output valid_i, opcode_i, op0_i, op1_i,
    input  result_o, complete_o, busy_o
  );

  modport slave (
    input  valid_i, opcode_i, op0_i, op1_i,
    output result_o, complete_o, busy_o
  );
endinterface

// File: rtl/copro_arith_unit.sv
// Multicycle coprocessor datapath: single-cycle add/sub, iterative shift-add
// unsigned multiply returning either half of the 2*WIDTH-bit product.
module copro_arith_unit #(
  parameter int WIDTH    = 32,
  parameter int OPCODE_W = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  copro_arith_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [2*WIDTH-1:0]   p;
  logic [2*WIDTH-1:0]   p_step;
  logic [WIDTH-1:0]     m;
  logic [WIDTH:0]       upper_sum;
  logic [CNT_W-1:0]     cnt;
  logic                 sel_hi;
  logic [WIDTH-1:0]     result;
  logic                 complete;
  logic [WIDTH-1:0]     alu;
  logic                 accept;
  logic                 is_mul;
  logic                 last_step;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    accept     = 1'b0;
    alu        = '0;
    upper_sum  = {1'b0, p[2*WIDTH-1:WIDTH]};
    is_mul     = (bus.opcode_i == OPCODE_W'(2)) || (bus.opcode_i == OPCODE_W'(3));
    last_step  = (cnt == CNT_W'(1));

    case (bus.opcode_i)
      OPCODE_W'(0): alu = bus.op0_i + bus.op1_i;
      OPCODE_W'(1): alu = bus.op0_i - bus.op1_i;
      default:      alu = '0;
    endcase

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, keeping the carry so the right shift does not lose it.
    if (p[0]) begin
      upper_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
    end
    p_step = {upper_sum, p[WIDTH-1:1]};

    case (state)
      IDLE: begin
        accept = bus.valid_i;
        if (accept && is_mul) begin
          state_next = MUL;
        end
      end
      MUL: begin
        if (last_step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the engine registers are cleared too, so an aborted multiply leaves nothing behind.
      p        <= '0;
      m        <= '0;
      cnt      <= '0;
      sel_hi   <= 1'b0;
      result   <= '0;
      complete <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          p      <= {{WIDTH{1'b0}}, bus.op1_i};
          m      <= bus.op0_i;
          cnt    <= CNT_W'(WIDTH);
          sel_hi <= (bus.opcode_i == OPCODE_W'(3));
        end else begin
          result   <= alu;
          complete <= 1'b1;
        end
      end else if (state == MUL) begin
        p   <= p_step;
        cnt <= cnt - CNT_W'(1);
        if (last_step) begin
          result   <= sel_hi ? p_step[2*WIDTH-1:WIDTH] : p_step[WIDTH-1:0];
          complete <= 1'b1;
        end
      end
    end
  end

  assign bus.result_o   = result;
  assign bus.complete_o = complete;
  assign bus.busy_o     = (state == MUL);
endmodule
